// File: rtl/rv32m_pkg.sv
// Shared constants, func3 codes and FSM encoding for the sequential RV M-extension unit.
package rv32m_pkg;

    localparam logic [6:0] OPCODE_OP = 7'b0110011;
    localparam logic [6:0] FUNC7_M   = 7'h01;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic is_m_op(input logic [31:0] ir);
        return (ir[6:0] == OPCODE_OP) && (ir[31:25] == FUNC7_M);
    endfunction

endpackage

// File: rtl/rv_div_iter.sv
// Unsigned restoring radix-2 divider: one quotient bit per cycle, XLEN cycles per divide.
module rv_div_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0]  rem_r;
    logic [XLEN-1:0]  quo_r;
    logic [XLEN-1:0]  dsr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;

    logic [XLEN:0]    shifted_s;
    logic [XLEN:0]    diff_s;
    logic [XLEN-1:0]  rem_nx_s;
    logic [XLEN-1:0]  quo_nx_s;

    // One shift-subtract step; a set diff MSB means the trial subtraction went negative.
    always_comb begin
        shifted_s = {rem_r, quo_r[XLEN-1]};
        diff_s    = shifted_s - {1'b0, dsr_r};
        rem_nx_s  = {XLEN{1'b0}};
        quo_nx_s  = {XLEN{1'b0}};
        if (diff_s[XLEN]) begin
            rem_nx_s = shifted_s[XLEN-1:0];
            quo_nx_s = {quo_r[XLEN-2:0], 1'b0};
        end else begin
            rem_nx_s = diff_s[XLEN-1:0];
            quo_nx_s = {quo_r[XLEN-2:0], 1'b1};
        end
    end

    // Iteration registers and the down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r  <= {XLEN{1'b0}};
            quo_r  <= {XLEN{1'b0}};
            dsr_r  <= {XLEN{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
        end else if (start) begin
            rem_r  <= {XLEN{1'b0}};
            quo_r  <= dividend;
            dsr_r  <= divisor;
            cnt_r  <= CNT_W'(XLEN - 1);
            busy_r <= 1'b1;
        end else if (busy_r) begin
            rem_r <= rem_nx_s;
            quo_r <= quo_nx_s;
            if (cnt_r == {CNT_W{1'b0}}) begin
                busy_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end
    end

    assign done      = busy_r && (cnt_r == {CNT_W{1'b0}});
    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/rv_muldiv_seq.sv
// Multi-cycle RISC-V M-extension unit: registered multiplier, iterative divider,
// valid/ready handshake on both sides and a synchronous flush.
module rv_muldiv_seq
    import rv32m_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    input  logic            iFLUSH,
    input  logic            iVALID,
    output logic            oREADY,
    input  logic [31:0]     iIR,
    input  logic [XLEN-1:0] iALU_IN1,
    input  logic [XLEN-1:0] iALU_IN2,
    output logic            oVALID,
    input  logic            iREADY,
    output logic [4:0]      oRD,
    output logic [XLEN-1:0] oALU_OUT,
    output logic            oILLEGAL,
    output logic            oBUSY
);

    state_t state_r, state_nx_s;

    logic [2:0]      f3_r;
    logic [4:0]      rd_r;
    logic            illegal_r, special_r, is_rem_r, neg_q_r, neg_r_r;
    logic [XLEN:0]   mul_a_r, mul_b_r;
    logic [XLEN-1:0] spec_res_r;

    logic            valid_r, busy_r, ill_out_r;
    logic [4:0]      rd_out_r;
    logic [XLEN-1:0] alu_out_r;

    logic [2:0]      f3_s;
    logic            illegal_s, ready_s, accept_s;
    logic            signed_div_s, div_zero_s, div_ovf_s, special_s, ord_div_s;
    logic            neg1_s, neg2_s, sext1_s, sext2_s;
    logic [XLEN-1:0] mag1_s, mag2_s, spec_val_s;

    logic [2*XLEN+1:0] mul_a_ext_s, mul_b_ext_s, prod_s;
    logic [XLEN-1:0]   result_s;
    logic              div_done_s;
    logic [XLEN-1:0]   div_quo_s, div_rem_s;
    logic              unused_bits_s;

    assign f3_s      = iIR[14:12];
    assign illegal_s = !is_m_op(iIR);
    assign ready_s   = !iFLUSH && ((state_r == ST_IDLE) || ((state_r == ST_DONE) && iREADY));
    assign accept_s  = iVALID && ready_s;
    assign oREADY    = ready_s;

    // Operand conditioning at accept: sign extension for multiply, magnitudes and
    // special-case results for divide.
    always_comb begin
        sext1_s      = (f3_s == F3_MULH) || (f3_s == F3_MULHSU);
        sext2_s      = (f3_s == F3_MULH);
        signed_div_s = (f3_s == F3_DIV) || (f3_s == F3_REM);
        neg1_s       = signed_div_s && iALU_IN1[XLEN-1];
        neg2_s       = signed_div_s && iALU_IN2[XLEN-1];
        mag1_s       = neg1_s ? ({XLEN{1'b0}} - iALU_IN1) : iALU_IN1;
        mag2_s       = neg2_s ? ({XLEN{1'b0}} - iALU_IN2) : iALU_IN2;
        div_zero_s   = (iALU_IN2 == {XLEN{1'b0}});
        div_ovf_s    = signed_div_s && (iALU_IN1 == {1'b1, {(XLEN-1){1'b0}}})
                                    && (iALU_IN2 == {XLEN{1'b1}});
        special_s    = !illegal_s && f3_s[2] && (div_zero_s || div_ovf_s);
        ord_div_s    = !illegal_s && f3_s[2] && !div_zero_s && !div_ovf_s;
        spec_val_s   = {XLEN{1'b0}};
        if (div_zero_s) begin
            spec_val_s = f3_s[1] ? iALU_IN1 : {XLEN{1'b1}};
        end else begin
            spec_val_s = f3_s[1] ? {XLEN{1'b0}} : iALU_IN1;
        end
    end

    // Request capture; inputs are ignored after the accepting edge.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            f3_r       <= 3'd0;
            rd_r       <= 5'd0;
            illegal_r  <= 1'b0;
            special_r  <= 1'b0;
            is_rem_r   <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            mul_a_r    <= {(XLEN+1){1'b0}};
            mul_b_r    <= {(XLEN+1){1'b0}};
            spec_res_r <= {XLEN{1'b0}};
        end else if (accept_s) begin
            f3_r       <= f3_s;
            rd_r       <= iIR[11:7];
            illegal_r  <= illegal_s;
            special_r  <= special_s;
            is_rem_r   <= f3_s[1];
            neg_q_r    <= neg1_s ^ neg2_s;
            neg_r_r    <= neg1_s;
            mul_a_r    <= {sext1_s & iALU_IN1[XLEN-1], iALU_IN1};
            mul_b_r    <= {sext2_s & iALU_IN2[XLEN-1], iALU_IN2};
            spec_res_r <= spec_val_s;
        end
    end

    rv_div_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_div (
        .clk       (iCLK),
        .rst_n     (iRST_N),
        .start     (accept_s && ord_div_s),
        .dividend  (mag1_s),
        .divisor   (mag2_s),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Sign-extended operands multiply modulo 2^(2*XLEN+2), which is exact for the 33x33 product.
    assign mul_a_ext_s   = {{(XLEN+1){mul_a_r[XLEN]}}, mul_a_r};
    assign mul_b_ext_s   = {{(XLEN+1){mul_b_r[XLEN]}}, mul_b_r};
    assign prod_s        = mul_a_ext_s * mul_b_ext_s;
    assign unused_bits_s = ^{iIR[24:15], prod_s[2*XLEN+1:2*XLEN]};

    // Result selection for the cycle that enters DONE.
    always_comb begin
        result_s = {XLEN{1'b0}};
        case (state_r)
            ST_MUL: begin
                if (illegal_r) begin
                    result_s = {XLEN{1'b0}};
                end else if (special_r) begin
                    result_s = spec_res_r;
                end else begin
                    case (f3_r)
                        F3_MUL:                       result_s = prod_s[XLEN-1:0];
                        F3_MULH, F3_MULHSU, F3_MULHU: result_s = prod_s[2*XLEN-1:XLEN];
                        default:                      result_s = {XLEN{1'b0}};
                    endcase
                end
            end
            ST_FIX: begin
                if (is_rem_r) begin
                    result_s = neg_r_r ? ({XLEN{1'b0}} - div_rem_s) : div_rem_s;
                end else begin
                    result_s = neg_q_r ? ({XLEN{1'b0}} - div_quo_s) : div_quo_s;
                end
            end
            default: result_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_nx_s = state_r;
        if (iFLUSH) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_nx_s = ord_div_s ? ST_DIV : ST_MUL;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_MUL: state_nx_s = ST_DONE;
                ST_DIV: begin
                    if (div_done_s) begin
                        state_nx_s = ST_FIX;
                    end else begin
                        state_nx_s = ST_DIV;
                    end
                end
                ST_FIX: state_nx_s = ST_DONE;
                ST_DONE: begin
                    if (accept_s) begin
                        state_nx_s = ord_div_s ? ST_DIV : ST_MUL;
                    end else if (iREADY) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State register and registered outputs; the result is latched only on entry to DONE.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_r   <= ST_IDLE;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            ill_out_r <= 1'b0;
            rd_out_r  <= 5'd0;
            alu_out_r <= {XLEN{1'b0}};
        end else begin
            state_r <= state_nx_s;
            valid_r <= (state_nx_s == ST_DONE);
            busy_r  <= (state_nx_s != ST_IDLE);
            if ((state_nx_s == ST_DONE) && (state_r != ST_DONE)) begin
                alu_out_r <= result_s;
                rd_out_r  <= rd_r;
                ill_out_r <= illegal_r;
            end
        end
    end

    assign oVALID   = valid_r;
    assign oBUSY    = busy_r;
    assign oILLEGAL = ill_out_r;
    assign oRD      = rd_out_r;
    assign oALU_OUT = alu_out_r;

endmodule

// File: tb/tb_rv_muldiv_seq.sv
// Self-checking bench for rv_muldiv_seq (XLEN = 32): arithmetic reference model,
// per-cycle scoreboard compare, directed vectors and a randomised run.
module tb_rv_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready;
    logic [31:0] ir = 32'd0;
    logic [31:0] in1 = 32'd0;
    logic [31:0] in2 = 32'd0;
    logic        out_valid;
    logic        cons_ready = 1'b1;
    logic [4:0]  out_rd;
    logic [31:0] out_val;
    logic        out_ill;
    logic        out_busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_acc = 0;
    bit rnd_mode = 1'b0;

    typedef struct {
        logic [31:0] val;
        logic        ill;
        logic [4:0]  rd;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    bit   seen = 1'b0;

    rv_muldiv_seq #(.XLEN(32)) dut (
        .iCLK     (clk),
        .iRST_N   (rst_n),
        .iFLUSH   (flush),
        .iVALID   (in_valid),
        .oREADY   (out_ready),
        .iIR      (ir),
        .iALU_IN1 (in1),
        .iALU_IN2 (in2),
        .oVALID   (out_valid),
        .iREADY   (cons_ready),
        .oRD      (out_rd),
        .oALU_OUT (out_val),
        .oILLEGAL (out_ill),
        .oBUSY    (out_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [4:0] rd);
        return {7'h01, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    // Reference: plain 64-bit arithmetic following the RISC-V M rules.
    function automatic exp_t model(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, ua, ub, t;
        logic [63:0] p;
        logic        ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        e.rd  = op[11:7];
        e.ill = 1'b0;
        e.lat = 2;
        e.acc = 0;
        e.val = 32'd0;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (op[6:0] != 7'b0110011 || op[31:25] != 7'h01) begin
            e.ill = 1'b1;
            return e;
        end
        case (op[14:12])
            3'd0: begin p = sa * sb; e.val = p[31:0];  end
            3'd1: begin p = sa * sb; e.val = p[63:32]; end
            3'd2: begin p = sa * ub; e.val = p[63:32]; end
            3'd3: begin p = ua * ub; e.val = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) e.val = 32'hFFFF_FFFF;
                else if (ovf)   e.val = a;
                else begin t = sa / sb; e.val = t[31:0]; e.lat = 34; end
            end
            3'd5: begin
                if (b == 32'd0) e.val = 32'hFFFF_FFFF;
                else begin t = ua / ub; e.val = t[31:0]; e.lat = 34; end
            end
            3'd6: begin
                if (b == 32'd0) e.val = a;
                else if (ovf)   e.val = 32'd0;
                else begin t = sa % sb; e.val = t[31:0]; e.lat = 34; end
            end
            default: begin
                if (b == 32'd0) e.val = a;
                else begin t = ua % ub; e.val = t[31:0]; e.lat = 34; end
            end
        endcase
        return e;
    endfunction

    // Scoreboard compare: every oVALID cycle against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || flush) begin
            sb.delete();
            seen = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = sb[0];
                    chk("result", {32'd0, out_val}, {32'd0, e.val});
                    chk("rd", {59'd0, out_rd}, {59'd0, e.rd});
                    chk("illegal", {63'd0, out_ill}, {63'd0, e.ill});
                    if (!seen) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    seen = 1'b1;
                    if (cons_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
            if (in_valid && out_ready) begin
                e = model(ir, in1, in2);
                e.acc = cyc;
                sb.push_back(e);
            end
        end
    end

    // Presents one request and returns one cycle after it was accepted.
    task automatic issue(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        ir = op; in1 = a; in2 = b; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        last_acc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ir = $urandom; in1 = $urandom; in2 = $urandom;
    endtask

    task automatic drain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (sb.size() == 0 && !out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    // Pins the model to a hand-computed value and latency, then runs the op on the DUT.
    task automatic directed(input string nm, input logic [31:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] val, input int lat);
        exp_t e;
        e = model(op, a, b);
        chk({nm, "_model_val"}, {32'd0, e.val}, {32'd0, val});
        chk({nm, "_model_lat"}, 64'(e.lat), 64'(lat));
        issue(op, a, b);
        drain(100);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 20);
            5:       return 32'd0 - $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_mode) cons_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int a0, a1, a2, a3;
        logic [31:0] held;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, out_busy}, 64'd0);
        chk("rst_out", {32'd0, out_val}, 64'd0);
        chk("rst_rd", {59'd0, out_rd}, 64'd0);
        chk("rst_ill", {63'd0, out_ill}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        directed("mul",     mk_ir(3'd0, 5'd3), 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
        directed("mulhu",   mk_ir(3'd3, 5'd4), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        directed("mulhsu",  mk_ir(3'd2, 5'd5), 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 2);
        directed("mulh",    mk_ir(3'd1, 5'd6), 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
        directed("div",     mk_ir(3'd4, 5'd7), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        directed("rem",     mk_ir(3'd6, 5'd8), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        directed("divu",    mk_ir(3'd5, 5'd9), 32'd100, 32'd7, 32'd14, 34);
        directed("remu",    mk_ir(3'd7, 5'd10), 32'd100, 32'd7, 32'd2, 34);
        directed("div0",    mk_ir(3'd4, 5'd11), 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        directed("remu0",   mk_ir(3'd7, 5'd12), 32'd5, 32'd0, 32'd5, 2);
        directed("div_ovf", mk_ir(3'd4, 5'd13), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        directed("rem_ovf", mk_ir(3'd6, 5'd14), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
        directed("illegal", {7'h00, 5'd2, 5'd1, 3'd0, 5'd15, 7'b0110011}, 32'd1, 32'd2, 32'd0, 2);
        directed("badopc",  {7'h01, 5'd2, 5'd1, 3'd0, 5'd16, 7'b0010011}, 32'd3, 32'd4, 32'd0, 2);

        // Back-to-back multiplies with the consumer always ready.
        @(posedge clk); #1;
        issue(mk_ir(3'd0, 5'd1), 32'd2, 32'd3);  a0 = last_acc;
        issue(mk_ir(3'd0, 5'd2), 32'd4, 32'd5);  a1 = last_acc;
        issue(mk_ir(3'd0, 5'd3), 32'd6, 32'd7);  a2 = last_acc;
        issue(mk_ir(3'd0, 5'd4), 32'd8, 32'd9);  a3 = last_acc;
        chk("b2b_gap1", 64'(a1 - a0), 64'd2);
        chk("b2b_gap2", 64'(a2 - a1), 64'd2);
        chk("b2b_gap3", 64'(a3 - a2), 64'd2);
        drain(50);

        // Back-pressure: the result must hold and oREADY stay low.
        cons_ready = 1'b0;
        issue(mk_ir(3'd0, 5'd21), 32'd11, 32'd13);
        @(negedge clk);
        @(negedge clk);
        held = out_val;
        for (int i = 0; i < 5; i++) begin
            chk("hold_ready", {63'd0, out_ready}, 64'd0);
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_val", {32'd0, out_val}, 64'd143);
            @(negedge clk);
        end
        chk("hold_stable", {32'd0, out_val}, {32'd0, held});
        @(posedge clk); #1;
        cons_ready = 1'b1;
        drain(20);

        // Flush in the middle of a divide.
        issue(mk_ir(3'd5, 5'd22), 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {63'd0, out_busy}, 64'd0);
        repeat (40) @(negedge clk);
        directed("mul_after_flush", mk_ir(3'd0, 5'd23), 32'd3, 32'd4, 32'd12, 2);

        // Asynchronous reset in the middle of a divide.
        issue(mk_ir(3'd4, 5'd24), 32'd1000, 32'd7);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_busy", {63'd0, out_busy}, 64'd0);
        chk("arst_out", {32'd0, out_val}, 64'd0);
        chk("arst_rd", {59'd0, out_rd}, 64'd0);
        chk("arst_ill", {63'd0, out_ill}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        @(posedge clk); #1;

        // Randomised mix with consumer back-pressure.
        rnd_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] op;
            op = mk_ir(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 15) == 0) op[31:25] = 7'h20;
            issue(op, pick(), pick());
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rnd_mode = 1'b0;
        #1 cons_ready = 1'b1;
        drain(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv_muldiv_seq.md
Name: rv_muldiv_seq

Overview:
Parametrised, multi-cycle M-extension execution unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for the core ALU path.
- Replaces the single-cycle combinational multiply/divide with a registered multiplier and an iterative radix-2 divider, so no full-width divide sits in the critical path.
- Adds correct signed semantics, RISC-V divide-by-zero and overflow results, a valid/ready handshake and a flush.
- Sits beside the base ALU; the issue stage holds the instruction until oREADY and retires on oVALID && iREADY.

Parameters:
XLEN, 32, operand/result width (32 or 64).
CNT_W, $clog2(XLEN)+1, width of the divider iteration counter.

Ports:
iCLK  in  1  clock, rising edge.
iRST_N  in  1  reset; asynchronous assert, active-low; synchronous deassertion supplied externally.
iFLUSH  in  1  synchronous abort of any in-flight operation.
iVALID  in  1  request valid.
oREADY  out  1  unit can accept a request this cycle.
iIR  in  32  instruction word; opcode, func3, func7, rd decoded internally.
iALU_IN1  in  XLEN  rs1 value.
iALU_IN2  in  XLEN  rs2 value.
oVALID  out  1  result valid.
iREADY  in  1  consumer accepts result.
oRD  out  5  rd of the completing instruction.
oALU_OUT  out  XLEN  result.
oILLEGAL  out  1  qualifies oVALID: request was not an M-extension op (opcode != 7'b0110011 or func7 != 7'h01).
oBUSY  out  1  state != IDLE.

Behaviour:
- Reset (iRST_N = 0, async): state = IDLE; oVALID, oILLEGAL, oBUSY = 0; oALU_OUT = 0; oRD = 0; counter = 0. Reset mid-operation discards the operation silently.
- Acceptance: a request is accepted on an edge where iVALID && oREADY. At that edge iIR fields, the operands and rd are captured; later changes on the inputs are ignored.
- oREADY = !iFLUSH && (state == IDLE || (state == DONE && iREADY)). This gives back-to-back issue with zero bubble when the consumer takes the result.
- States: IDLE, MUL, DIV, FIX, DONE.
  - IDLE -> MUL on accepted MUL* op, illegal op, or special-case divide.
  - IDLE -> DIV on an accepted ordinary divide/remainder.
  - MUL -> DONE after 1 cycle.
  - DIV -> FIX after XLEN cycles.
  - FIX -> DONE after 1 cycle.
  - DONE -> IDLE on iREADY with no new accept; DONE -> MUL/DIV on iREADY with a new accept.
- Latency, counted from the acceptance cycle to the first oVALID cycle:
  - MUL* ops, illegal ops, special-case divides: 2.
  - Ordinary divides: XLEN + 2 (34 for XLEN = 32).
- Multiply: (XLEN+1)-bit operands, sign- or zero-extended per func3, giving a 2*XLEN+2 product.
  - MUL returns the low XLEN bits.
  - MULH (s*s), MULHSU (s*u) and MULHU (u*u) return bits [2*XLEN-1:XLEN].
- Divide, ordinary case:
  - Signed ops take magnitudes at accept.
  - Restoring shift-subtract loop, one quotient bit per cycle, counter runs XLEN-1 down to 0.
  - FIX negates the quotient if the operand signs differ (DIV). It negates the remainder if the dividend is negative (REM), so the remainder sign follows the dividend.
- Divide special cases, detected at accept and bypassing DIV:
  - Divisor 0: quotient = all ones; remainder = dividend (both signed and unsigned).
  - Signed overflow (dividend = 1 << (XLEN-1), divisor = all ones): DIV = dividend; REM = 0.
- Illegal op: result 0, oILLEGAL = 1, latency 2; no exception is raised here.
- Output hold: while oVALID && !iREADY, oALU_OUT, oRD and oILLEGAL are stable. oVALID deasserts the edge after the handshake unless a new result completes.
- Flush: iFLUSH = 1 at an edge forces state = IDLE and oVALID = 0. It has priority over acceptance and completion in the same cycle (oREADY is 0 while iFLUSH is high).
- oALU_OUT is updated only on entry to DONE, never combinationally from the inputs.

Decomposition:
- Shared package rv32m_pkg holds:
  - OPCODE_OP = 7'b0110011 and FUNC7_M = 7'h01.
  - func3 constants F3_MUL..F3_REMU (0..7).
  - State encoding enum.
- One sub-module, rv_div_iter (XLEN):
  - Inputs: start, dividend/divisor magnitudes.
  - Outputs: done pulse, unsigned quotient and remainder; contains the counter and shift registers.
  - Sign fix, special cases and handshake stay in the top level.

Test Plan:
1. MUL 7 * -3 (XLEN=32) -> oALU_OUT = 0xFFFFFFEB, oVALID 2 cycles after accept. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU -1 * 2 -> 0xFFFFFFFF.
2. DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2. Each has oVALID exactly 34 cycles after accept.
3. DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0. All with latency 2.
4. Back-to-back MUL with iREADY tied 1 -> one result per 2 cycles. Then hold iREADY = 0 for 5 cycles -> oALU_OUT/oRD stable and oREADY = 0 until the handshake.
5. Assert iFLUSH 10 cycles into a DIV -> oBUSY = 0 next cycle, no oVALID. A following MUL 3*4 returns 12 with latency 2. Deassert iRST_N mid-DIV -> all outputs 0 immediately (async).
6. iIR with func7 = 0x00 (ADD) -> oILLEGAL = 1, oALU_OUT = 0, latency 2. Randomised 10k ops vs reference model, including XLEN = 64 build.
